// File: rtl/icache_line_filler_pkg.sv
// icache_pkg: constants, filler state encoding and line-width helper
// shared by the instruction-cache variants and the line filler.
package icache_pkg;
    localparam int BYTE_OFFSET_BITS = 2;
    localparam int BLOCK_SIZE = 4;
    typedef enum logic [1:0] {IDLE, FETCH, RESP, DRAIN} filler_state_e;
    function automatic int line_bits(input int num_blocks);
        return 8 * BLOCK_SIZE * num_blocks;
    endfunction
endpackage

// File: rtl/icache_line_filler_if.sv
// icache_line_filler_if: cache-side line request bus and narrow backing-memory bus.
interface icache_req_if #(parameter int NUM_BLOCKS = 4);
    logic valid;
    logic ready;
    logic [31:0] addr;
    logic [icache_pkg::line_bits(NUM_BLOCKS)-1:0] rdata;
    modport master (output valid, addr, input ready, rdata);
    modport slave (input valid, addr, output ready, rdata);
endinterface

interface icache_bmem_if;
    logic valid;
    logic ready;
    logic [31:0] addr;
    logic [31:0] rdata;
    modport master (output valid, addr, input ready, rdata);
    modport slave (input valid, addr, output ready, rdata);
endinterface

// File: rtl/icache_line_filler.sv
// icache_line_filler: fetches one cache line as NUM_BLOCKS sequential word beats
// and returns it as one wide line with a single-cycle ready pulse.
module icache_line_filler
    import icache_pkg::*;
#(
    parameter int NUM_BLOCKS = 4
) (
    input  logic          clk,
    input  logic          resetn,
    icache_req_if.slave   req,
    icache_bmem_if.master bmem,
    output logic [31:0]   fill_count
);
    localparam int OFFSET_BITS = $clog2(NUM_BLOCKS);
    localparam int LINE_W = line_bits(NUM_BLOCKS);
    localparam logic [31:0] LINE_MASK = 32'((1 << (OFFSET_BITS + BYTE_OFFSET_BITS)) - 1);
    localparam logic [OFFSET_BITS-1:0] LAST = OFFSET_BITS'(NUM_BLOCKS - 1);

    filler_state_e state_q, state_d;
    logic [OFFSET_BITS-1:0] cnt_q, cnt_d;
    logic abort_q, abort_d, bvalid_q, bvalid_d, ready_q, ready_d;
    logic [31:0] addr_q, addr_d, fill_q, fill_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic beat, last, abort_now;

    assign beat = state_q == FETCH && bmem.ready;
    assign last = cnt_q == LAST;
    // a drop of mem_req_valid in the current cycle already ends the in-flight beat's fill
    assign abort_now = abort_q || !req.valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            abort_q  <= 1'b0;
            bvalid_q <= 1'b0;
            ready_q  <= 1'b0;
            addr_q   <= '0;
            fill_q   <= '0;
            line_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            abort_q  <= abort_d;
            bvalid_q <= bvalid_d;
            ready_q  <= ready_d;
            addr_q   <= addr_d;
            fill_q   <= fill_d;
            line_q   <= line_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = req.valid ? FETCH : IDLE;
            FETCH:   state_d = !bmem.ready ? FETCH : abort_now ? IDLE : last ? RESP : FETCH;
            RESP:    state_d = DRAIN;
            DRAIN:   state_d = req.valid ? DRAIN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d    = cnt_q;
        abort_d  = abort_q;
        bvalid_d = bvalid_q;
        addr_d   = addr_q;
        line_d   = line_q;
        if (state_q == IDLE && req.valid) begin
            addr_d   = req.addr & ~LINE_MASK;
            cnt_d    = '0;
            abort_d  = 1'b0;
            bvalid_d = 1'b1;
        end
        if (state_q == FETCH) abort_d = abort_now;
        if (beat) begin
            line_d[32*cnt_q +: 32] = bmem.rdata;
            bvalid_d = !(last || abort_now);
            cnt_d    = last ? cnt_q : cnt_q + OFFSET_BITS'(1);
            addr_d   = last ? addr_q : addr_q + 32'd4;
        end
        ready_d = state_d == RESP;
        fill_d  = fill_q + 32'(state_q == RESP);
    end

    assign req.ready  = ready_q;
    assign req.rdata  = line_q;
    assign bmem.valid = bvalid_q;
    assign bmem.addr  = addr_q;
    assign fill_count = fill_q;
endmodule

// File: tb/tb_icache_line_filler.sv
// tb_icache_line_filler: directed and randomized checks of the line filler against
// a word-level memory model and a small direct-mapped cache scoreboard.
module tb_icache_line_filler;
    localparam int NB = 4;
    localparam int LW = 32 * NB;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic [31:0] fill_count;
    int checks = 0;
    int errors = 0;
    int lat = 1;
    bit rand_lat = 1'b0;
    int bv_cycles = 0;
    int wl = -1;
    logic [31:0] pend = '0;
    logic [31:0] beats[$];

    icache_req_if #(.NUM_BLOCKS(NB)) rq ();
    icache_bmem_if bm ();

    icache_line_filler #(.NUM_BLOCKS(NB)) dut (
        .clk(clk), .resetn(resetn), .req(rq), .bmem(bm), .fill_count(fill_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] base_of(input logic [31:0] a);
        return a & ~32'(NB * 4 - 1);
    endfunction

    function automatic logic [LW-1:0] exp_line(input logic [31:0] base);
        logic [LW-1:0] l;
        for (int k = 0; k < NB; k++) l[32*k +: 32] = mem_word(base + 32'(4 * k));
        return l;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Backing memory: each beat waits lat (or a random 0..3) cycles, then returns mem_word.
    initial begin
        bm.ready = 1'b0;
        bm.rdata = '0;
        forever begin
            @(negedge clk);
            if (bm.ready && resetn) beats.push_back(pend);
            bm.ready = 1'b0;
            if (bm.valid) bv_cycles++;
            if (!bm.valid) wl = -1;
            else begin
                if (wl < 0) wl = rand_lat ? int'($urandom_range(0, 3)) : lat;
                if (wl == 0) begin
                    bm.ready = 1'b1;
                    bm.rdata = mem_word(bm.addr);
                    pend = bm.addr;
                    wl = -1;
                end else wl--;
            end
        end
    end

    task automatic fill(input logic [31:0] a, input int hold, output logic [LW-1:0] line,
                        output int lat_c, output int extra);
        @(negedge clk);
        rq.valid = 1'b1;
        rq.addr = a;
        lat_c = 0;
        do begin
            @(negedge clk);
            lat_c++;
            if (lat_c == 1) rq.addr = $urandom;
        end while (!rq.ready && lat_c < 200);
        chk("ready_seen", rq.ready, 1);
        line = rq.rdata;
        extra = 0;
        repeat (hold) begin
            @(negedge clk);
            extra += int'(rq.ready) + int'(bm.valid);
        end
        rq.valid = 1'b0;
        @(negedge clk);
        extra += int'(rq.ready) + int'(bm.valid);
    endtask

    task automatic fill_check(input string tag, input logic [31:0] a, input int hold,
                              input bit timed, output logic [LW-1:0] line);
        int b0, v0, lc, ex;
        logic [31:0] base;
        b0 = beats.size();
        v0 = bv_cycles;
        base = base_of(a);
        fill(a, hold, line, lc, ex);
        chk({tag, "_line"}, line, exp_line(base));
        chk({tag, "_one_pulse"}, ex, 0);
        chk({tag, "_beats"}, beats.size() - b0, NB);
        for (int k = 0; k < NB; k++)
            if (b0 + k < beats.size()) chk({tag, "_beat_addr"}, beats[b0+k], base + 32'(4 * k));
        // accept cycle + NB beats of (lat+1) cycles each + ready cycle, counted from the accept cycle
        if (timed) begin
            chk({tag, "_latency"}, lc + 1, 1 + NB * (lat + 1) + 1);
            chk({tag, "_bvalid_cycles"}, bv_cycles - v0, NB * (lat + 1));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [LW-1:0] line;
        logic [31:0] fc0, a;
        logic [LW-1:0] cdata[4];
        logic [25:0] ctag[4];
        bit cval[4];
        int b0, v0, pulses, misses, drop, inflight;
        rq.valid = 1'b0;
        rq.addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", rq.ready, 0);
        chk("rst_rdata", rq.rdata, 0);
        chk("rst_bvalid", bm.valid, 0);
        chk("rst_baddr", bm.addr, 0);
        chk("rst_fill_count", fill_count, 0);
        resetn = 1'b1;
        @(negedge clk);

        lat = 1;
        fill_check("basic", 32'h0000_1234, 0, 1, line);
        chk("basic_fill_count", fill_count, 1);

        lat = 0;
        fill_check("zero_wait", 32'h0000_0F08, 0, 1, line);
        chk("zero_wait_fill_count", fill_count, 2);

        lat = 3;
        drop = 6;
        fc0 = fill_count;
        b0 = beats.size();
        v0 = bv_cycles;
        @(negedge clk);
        rq.valid = 1'b1;
        rq.addr = 32'h0000_2000;
        repeat (drop) @(negedge clk);
        rq.valid = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            pulses += int'(rq.ready);
        end
        inflight = (drop - 1) / (lat + 1);
        chk("abort_no_ready", pulses, 0);
        chk("abort_beats", beats.size() - b0, inflight + 1);
        chk("abort_bvalid_cycles", bv_cycles - v0, (inflight + 1) * (lat + 1));
        chk("abort_bvalid_low", bm.valid, 0);
        chk("abort_fill_count", fill_count, fc0);
        fill_check("abort_next", 32'h0000_0040, 0, 1, line);
        chk("abort_next_fill_count", fill_count, fc0 + 1);

        lat = 2;
        fc0 = fill_count;
        fill_check("held", 32'h0000_0500, 3, 1, line);
        chk("held_fill_count", fill_count, fc0 + 1);
        fill_check("held_next", 32'h0000_0510, 0, 1, line);

        lat = 1;
        @(negedge clk);
        rq.valid = 1'b1;
        rq.addr = 32'h0000_3008;
        repeat (5) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("arst_ready", rq.ready, 0);
        chk("arst_rdata", rq.rdata, 0);
        chk("arst_bvalid", bm.valid, 0);
        chk("arst_baddr", bm.addr, 0);
        chk("arst_fill_count", fill_count, 0);
        rq.valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        fill_check("arst_next", 32'h0000_3008, 0, 1, line);
        chk("arst_next_fill_count", fill_count, 1);

        rand_lat = 1'b1;
        fc0 = fill_count;
        misses = 0;
        for (int i = 0; i < 4; i++) cval[i] = 1'b0;
        for (int n = 0; n < 100; n++) begin
            a = 32'($urandom_range(0, 63)) << 2;
            if (!(cval[a[5:4]] && ctag[a[5:4]] == a[31:6])) begin
                fill_check("cache_fill", a, 0, 0, line);
                cdata[a[5:4]] = line;
                ctag[a[5:4]] = a[31:6];
                cval[a[5:4]] = 1'b1;
                misses++;
            end
            chk("cache_word", cdata[a[5:4]][32*a[3:2] +: 32], mem_word(a));
        end
        chk("cache_fill_count", fill_count, fc0 + 32'(misses));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/icache_line_filler.md
# icache_line_filler

Memory-side responder for the instruction cache's line-fill port. It accepts one line request at a time from the cache (`mem_req_*`) and fetches the line as `NUM_BLOCKS` sequential 32-bit words over a narrow, variable-latency backing-memory port (`bmem_*`). It assembles the words into one wide line and returns it with a single-cycle `mem_req_ready` pulse. It sits between the icache and main memory / the instruction ROM.

## Interface
- `BLOCK_SIZE`, 4, bytes per block; fixed at 4 (one 32-bit word per block).
- `NUM_BLOCKS`, 4, blocks per cache line; power of two, ≥2.
- `clk` in 1 — clock; all logic on rising edge.
- `resetn` in 1 — reset: one clock; reset is asynchronous and active-low.
- `mem_req_valid` in 1 — cache line request; held high until `mem_req_ready` is seen.
- `mem_req_ready` out 1 — one-cycle pulse: the line is on `mem_req_rdata`.
- `mem_req_addr` in 32 — line address; sampled only at request acceptance.
- `mem_req_rdata` out 32*NUM_BLOCKS — assembled line; word k in bits [32k +: 32].
- `bmem_valid` out 1 — backing-memory read request.
- `bmem_ready` in 1 — backing memory has `bmem_rdata` for the current `bmem_addr`.
- `bmem_addr` out 32 — word address, 4-byte aligned.
- `bmem_rdata` in 32 — read word.
- `fill_count` out 32 — number of completed (non-aborted) fills; wraps at 2^32.

## Operation
- States: IDLE, FETCH, RESP, DRAIN.
- IDLE: when `mem_req_valid`=1, latch the base address as `mem_req_addr` with bits [OFFSET_BITS+1:0] cleared, where OFFSET_BITS = log2(NUM_BLOCKS). Then set `bmem_addr`=base, `bmem_valid`=1, beat counter=0, abort flag=0, and go to FETCH.
- FETCH: `bmem_valid` stays high. On each cycle with `bmem_ready`=1:
  - write `bmem_rdata` into buffer word[counter];
  - if counter≠NUM_BLOCKS−1: counter+1 and `bmem_addr`+4 on the same edge, with `bmem_valid` staying high;
  - on the last beat: `bmem_valid`←0, then go to RESP, or to IDLE if the abort flag is set.
- Abort: if `mem_req_valid`=0 in any FETCH cycle, set the sticky abort flag. The in-flight beat is never cancelled: `bmem_valid` stays high until that beat's `bmem_ready`. On that `bmem_ready`, drop `bmem_valid` and go to IDLE, with no `mem_req_ready` and no `fill_count` change.
- RESP: `mem_req_ready`=1 for exactly this cycle, then `fill_count`+1 and go to DRAIN.
- DRAIN: wait until `mem_req_valid`=0, then go to IDLE. This guarantees one pulse per request.
- `mem_req_rdata` is the buffer register. It is meaningful only while `mem_req_ready`=1, and it is held otherwise; beats overwrite it during the next fill.
- Changes on `mem_req_addr` after acceptance are ignored.
- Beat address arithmetic is 32-bit. The base alignment guarantees no carry out of the line.

## Timing
- Reset values: `mem_req_ready`=0, `mem_req_rdata`=0, `bmem_valid`=0, `bmem_addr`=0, `fill_count`=0, state=IDLE, counter=0, abort=0.
- Asserting `resetn` mid-fill drops `bmem_valid` immediately (asynchronous).
- Accept edge: `mem_req_valid` is sampled high in IDLE at edge E; `bmem_valid` is high from the cycle after E.
- The earliest `bmem_ready` for a beat is the first cycle its `bmem_valid`/`bmem_addr` are presented.
- `mem_req_ready` is high in the cycle after the last beat's `bmem_ready`.
- Latency from acceptance to ready = 1 + Σ(beat waits) + 1 cycles, plus the DRAIN cycle before the next accept.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Shared package `icache_pkg`:
  - `BYTE_OFFSET_BITS`=2;
  - filler state enum (IDLE/FETCH/RESP/DRAIN);
  - a line-width constant/function 8*BLOCK_SIZE*NUM_BLOCKS, shared with the icache variants.
- Single module, no sub-module: the FSM, counter and line buffer are too tightly coupled to split.

## Test plan
- Basic fill: request 0x0000_1234 with NUM_BLOCKS=4; bmem returns addr^0xA5A5_0000 with ready 1 cycle after each address.
  - Required: `bmem_addr` sequence 0x1230, 0x1234, 0x1238, 0x123C.
  - Required: `mem_req_rdata`={0xA5A5_123C, 0xA5A5_1238, 0xA5A5_1234, 0xA5A5_1230} with a 1-cycle ready.
  - Required: `fill_count`=1.
- Zero-wait memory: `bmem_ready` tied high.
  - Required: 4 beats on 4 consecutive cycles.
  - Required: ready 6 cycles after the accept edge.
  - Required: `bmem_valid` never drops mid-line.
- Abort: `mem_req_valid` drops during beat 1 with memory latency 3.
  - Required: beat 1 completes, `bmem_valid` falls, and no `mem_req_ready`.
  - Required: `fill_count` unchanged, and a following request to 0x40 fills correctly.
- Held valid: the cache keeps `mem_req_valid` high for 3 cycles after ready.
  - Required: exactly one ready pulse, no second fill, and acceptance only after valid falls.
- Async reset mid-fill: `resetn` low during beat 2.
  - Required: all outputs at reset values before the next edge.
  - Required: after release, a new request fills correctly.
- Back-to-back: 100 random line requests against the icache as the initiator.
  - Required: every cache hit returns the scoreboard word.
  - Required: `fill_count` equals the cache miss count.
